// File: rtl/uart_tx_sched.sv
// uart_tx_sched: byte FIFO plus a register-bus sequencer for the UART core.
// For each queued byte it writes TX (0x04), then CTRL (0x00) with the divisor
// and tx_en, then waits for the core's TX-done pulse.
// Optional watchdog on the TX-done wait: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int DEPTH    = 4,
    parameter int TO_SHIFT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [16:0]              cfg_clks_per_bit,
    input  logic                     req_valid,
    input  logic [7:0]               req_data,
    output logic                     req_ready,
    output logic                     ren,
    output logic                     we,
    output logic [7:0]               addr,
    output logic [31:0]              wdata,
    input  logic                     intr_tx,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = 17 + TO_SHIFT;

    typedef enum logic [1:0] {IDLE, WR_TX, WR_CTRL, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [16:0]   div_q;
    logic          push, pop, start, wd_fire;

    assign push  = req_valid && req_ready;
    // The head leaves the FIFO as the FSM moves from WR_CTRL to WAIT_DONE.
    assign pop   = (state_q == WR_CTRL);
    // A zero divisor holds the byte in the FIFO rather than sending garbage.
    assign start = en_i && (count != '0) && (cfg_clks_per_bit != '0);

    assign req_ready = (count != (AW+1)'(DEPTH));
    assign level     = count;
    assign busy      = (state_q != IDLE) || (count != '0);
    assign ren       = 1'b0;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= req_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Divisor is captured once per byte so mid-byte cfg changes are harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                     div_q <= '0;
        else if (state_q == IDLE && start) div_q <= cfg_clks_per_bit;
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [WDW-1:0] wd_cnt;
    logic [WDW-1:0] wd_limit;
    assign wd_limit = {div_q, {TO_SHIFT{1'b0}}} - 1'b1;
    assign wd_fire  = (wd_cnt == wd_limit);

    // Watchdog: zeroed on the way into WAIT_DONE, counts while waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                     wd_cnt <= '0;
        else if (state_q == WR_CTRL)     wd_cnt <= '0;
        else if (state_q == WAIT_DONE)   wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic [WDW-1:0] unused_wd;
    assign unused_wd = '0;
    assign wd_fire   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and bus decode; TX-done beats the watchdog on a tie.
    always_comb begin
        state_d     = state_q;
        we          = 1'b0;
        addr        = 8'h00;
        wdata       = 32'h0;
        done        = 1'b0;
        err_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = WR_TX;
            end
            WR_TX: begin
                we      = 1'b1;
                addr    = 8'h04;
                wdata   = {24'h0, mem[rd_ptr]};
                state_d = WR_CTRL;
            end
            WR_CTRL: begin
                we      = 1'b1;
                addr    = 8'h00;
                wdata   = {12'h0, div_q, 3'b001};
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (intr_tx) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (wd_fire) begin
                    err_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a byte scoreboard on the TX register.
module tb_uart_tx_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [16:0] cfg_clks_per_bit;
    logic        req_valid;
    logic [7:0]  req_data;
    logic        req_ready;
    logic        ren;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        intr_tx;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [2:0]  level;

    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    logic [16:0] exp_div = 17'd868;
    logic [7:0]  sb[$];

    uart_tx_sched #(.DEPTH(4), .TO_SHIFT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .cfg_clks_per_bit(cfg_clks_per_bit),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ren(ren), .we(we), .addr(addr), .wdata(wdata), .intr_tx(intr_tx),
        .busy(busy), .done(done), .err_timeout(err_timeout), .level(level)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    // Leaves the caller at the negedge of the CTRL write cycle.
    task automatic wait_ctrl();
        bit found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            smp();
            if (we && addr == 8'h00) found = 1'b1;
            else cyc();
        end
        if (!found) chk("ctrl_wait_bound", 32'd0, 32'd1);
    endtask

    // Bus monitor: TX bytes come off the scoreboard in order, CTRL word
    // carries the expected divisor with tx_en set.
    always @(negedge clk_i) begin
        if (rst_ni && we) begin
            wr_cnt++;
            if (addr == 8'h04) begin
                if (sb.size() == 0) chk("tx_unexpected", wdata, 32'hFFFF_FFFF);
                else chk("tx_byte", wdata, {24'h0, sb.pop_front()});
            end else begin
                chk("ctrl_addr", 32'(addr), 32'h0);
                chk("ctrl_word", wdata, {12'h0, exp_div, 3'b001});
            end
        end
    end

    initial begin
        logic [7:0] bytes [6];
        int pend;
        int ack;
        int base;
        bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

        rst_ni = 1'b1; en_i = 1'b1; cfg_clks_per_bit = 17'd868;
        req_valid = 1'b0; req_data = 8'h0; intr_tx = 1'b0;
        #3 rst_ni = 1'b0;

        // Reset values
        smp(); smp();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ren", 32'(ren), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        rst_ni = 1'b1;
        cyc();

        // Single byte 0xA5, cfg=868: timing of the write pair and done pulse
        req_valid = 1'b1; req_data = 8'hA5; sb.push_back(8'hA5);
        cyc();
        req_valid = 1'b0;
        smp(); chk("t1_level1", 32'(level), 32'd1); chk("t1_idle_we", 32'(we), 32'd0);
        cyc(); smp(); chk("t1_tx_we", 32'(we), 32'd1); chk("t1_tx_addr", 32'(addr), 32'h04);
        chk("t1_tx_wdata", wdata, 32'h0000_00A5);
        cyc(); smp(); chk("t1_ctrl_addr", 32'(addr), 32'h00); chk("t1_ctrl_wdata", wdata, 32'h0000_1B21);
        cyc(); smp(); chk("t1_wait_we", 32'(we), 32'd0); chk("t1_level0", 32'(level), 32'd0);
        chk("t1_busy_wait", 32'(busy), 32'd1);
        repeat (4) cyc();
        intr_tx = 1'b1;
        smp(); chk("t1_done", 32'(done), 32'd1);
        cyc(); intr_tx = 1'b0;
        smp(); chk("t1_done_1cyc", 32'(done), 32'd0); chk("t1_busy_end", 32'(busy), 32'd0);
        cyc();

        // Fill with start blocked: ready drops after the 4th accepted push
        en_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_data = bytes[i];
            smp();
            chk("t2_ready_fill", 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
            if (req_ready) sb.push_back(bytes[i]);
            cyc();
        end
        req_valid = 1'b0;
        smp(); chk("t2_level_full", 32'(level), 32'd4); chk("t2_busy_idle", 32'(busy), 32'd1);
        cyc();
        // Enable, reissue rejected bytes, ack each byte a few cycles in
        en_i = 1'b1; pend = 4; ack = 0;
        for (int c = 0; c < 300; c++) begin
            if (pend == 6 && sb.size() == 0 && !busy) break;
            req_valid = (pend < 6);
            req_data  = (pend < 6) ? bytes[pend] : 8'h00;
            smp();
            if (req_valid && req_ready) begin sb.push_back(req_data); pend++; end
            if (we && addr == 8'h00) ack = 3;
            cyc();
            intr_tx = 1'b0;
            if (ack > 0) begin ack--; if (ack == 0) intr_tx = 1'b1; end
        end
        req_valid = 1'b0; intr_tx = 1'b0;
        chk("t2_all_sent", 32'(pend), 32'd6);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_busy_end", 32'(busy), 32'd0);

        // Zero divisor stalls without dropping; 16 starts the next cycle
        cfg_clks_per_bit = 17'd0; exp_div = 17'd16;
        req_valid = 1'b1; req_data = 8'h3C; sb.push_back(8'h3C);
        cyc();
        req_valid = 1'b0; base = wr_cnt;
        repeat (5) cyc();
        smp(); chk("t3_no_write", 32'(wr_cnt - base), 32'd0);
        chk("t3_level_hold", 32'(level), 32'd1);
        cyc();
        cfg_clks_per_bit = 17'd16;
        cyc(); smp(); chk("t3_start_we", 32'(we), 32'd1); chk("t3_start_addr", 32'(addr), 32'h04);
        cyc(); smp(); chk("t3_ctrl_wdata", wdata, 32'h0000_0081);
        cyc(); intr_tx = 1'b1;
        smp(); chk("t3_done", 32'(done), 32'd1);
        cyc(); intr_tx = 1'b0;
        cyc();

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog: cfg=2 fires on the 32nd WAIT_DONE cycle, next byte follows
        cfg_clks_per_bit = 17'd2; exp_div = 17'd2;
        req_valid = 1'b1; req_data = 8'h55; sb.push_back(8'h55);
        cyc();
        req_data = 8'h66; sb.push_back(8'h66);
        cyc();
        req_valid = 1'b0;
        wait_ctrl();
        cyc();
        for (int k = 1; k <= 32; k++) begin
            smp();
            chk("t4_err_timing", 32'(err_timeout), (k == 32) ? 32'd1 : 32'd0);
            if (k < 32) cyc();
        end
        cyc(); smp(); chk("t4_idle_we", 32'(we), 32'd0);
        cyc(); smp(); chk("t4_next_we", 32'(we), 32'd1); chk("t4_next_data", wdata, 32'h66);
        cyc();
        // intr_tx on the limit cycle: done wins
        cyc();
        for (int k = 1; k <= 31; k++) begin
            smp(); chk("t5_no_err_early", 32'(err_timeout), 32'd0);
            cyc();
        end
        intr_tx = 1'b1;
        smp(); chk("t5_done_wins", 32'(done), 32'd1); chk("t5_err_masked", 32'(err_timeout), 32'd0);
        cyc(); intr_tx = 1'b0;
        smp(); chk("t5_done_clear", 32'(done), 32'd0);
        cyc();
`else
        // No watchdog: WAIT_DONE holds until intr_tx
        cfg_clks_per_bit = 17'd2; exp_div = 17'd2;
        req_valid = 1'b1; req_data = 8'h55; sb.push_back(8'h55);
        cyc();
        req_valid = 1'b0;
        wait_ctrl();
        cyc();
        for (int k = 1; k <= 40; k++) begin
            smp(); chk("t4_no_err", 32'(err_timeout), 32'd0);
            cyc();
        end
        smp(); chk("t4_still_busy", 32'(busy), 32'd1);
        cyc(); intr_tx = 1'b1;
        smp(); chk("t4_done", 32'(done), 32'd1);
        cyc(); intr_tx = 1'b0;
        cyc();
`endif

        // Reset during WAIT_DONE with 3 bytes still queued
        cfg_clks_per_bit = 17'd868; exp_div = 17'd868; en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_data = bytes[i]; sb.push_back(bytes[i]);
            cyc();
        end
        req_valid = 1'b0; en_i = 1'b1;
        wait_ctrl();
        cyc();
        smp(); chk("t6_level3", 32'(level), 32'd3);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_level_rst", 32'(level), 32'd0);
        chk("t6_ready_rst", 32'(req_ready), 32'd1);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_we_rst", 32'(we), 32'd0);
        sb.delete();
        smp(); smp();
        rst_ni = 1'b1; base = wr_cnt;
        repeat (10) cyc();
        smp();
        chk("t6_no_write", 32'(wr_cnt - base), 32'd0);
        chk("t6_level_after", 32'(level), 32'd0);
        chk("t6_busy_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
